// File: rtl/ysyx_25020047_wb_stage_if.sv
// Writeback stage bus: upstream instruction handshake, load-data return,
// and the commit-side outputs (register-file write, next PC, commit pulse).
interface ysyx_25020047_wb_stage_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_pc;
  logic [XLEN-1:0]   in_snpc;
  logic [XLEN-1:0]   in_result;
  logic [REG_AW-1:0] in_rd;
  logic [1:0]        in_wb_sel;
  logic              in_pc_sel;
  logic [1:0]        in_ld_size;
  logic              in_ld_unsigned;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;
  logic              rf_wen;
  logic [REG_AW-1:0] rf_waddr;
  logic [XLEN-1:0]   rf_wdata;
  logic [XLEN-1:0]   dnpc;
  logic              commit_valid;
  logic [XLEN-1:0]   commit_pc;

  // Upstream / environment side: drives instructions and load data.
  modport master (
    output in_valid, in_pc, in_snpc, in_result, in_rd, in_wb_sel, in_pc_sel,
           in_ld_size, in_ld_unsigned, mem_rvalid, mem_rdata,
    input  in_ready, rf_wen, rf_waddr, rf_wdata, dnpc, commit_valid, commit_pc
  );

  // Writeback stage side.
  modport slave (
    input  in_valid, in_pc, in_snpc, in_result, in_rd, in_wb_sel, in_pc_sel,
           in_ld_size, in_ld_unsigned, mem_rvalid, mem_rdata,
    output in_ready, rf_wen, rf_waddr, rf_wdata, dnpc, commit_valid, commit_pc
  );
endinterface

// File: rtl/ysyx_25020047_wb_stage.sv
// Registered writeback stage: captures one instruction per transfer, waits
// for load data when needed, then commits for exactly one cycle.
module ysyx_25020047_wb_stage #(
  parameter int          XLEN     = 32,
  parameter int          REG_AW   = 5,
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input logic                     clk,
  input logic                     rst,
  ysyx_25020047_wb_stage_if.slave bus
);
  localparam int OFFW = $clog2(XLEN / 8);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_MEM = 2'd1;
  localparam logic [1:0] COMMIT   = 2'd2;

  localparam logic [1:0] WB_MEM  = 2'd2;
  localparam logic [1:0] WB_SNPC = 2'd3;

  logic [1:0]        state_q;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   snpc_q;
  logic [XLEN-1:0]   result_q;
  logic [REG_AW-1:0] rd_q;
  logic [1:0]        wb_sel_q;
  logic              pc_sel_q;
  logic [1:0]        ld_size_q;
  logic              ld_unsigned_q;
  logic [XLEN-1:0]   ld_data_q;
  logic [XLEN-1:0]   dnpc_q;

  logic              accept;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   lo_mask;
  logic [XLEN-1:0]   ld_aligned;
  logic              ld_sign;
  int unsigned       ld_bits;

  assign bus.in_ready = !rst && (state_q != WAIT_MEM);
  assign accept       = bus.in_valid && bus.in_ready;

  // Align the bus word to the load offset, truncate to the access size, extend.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    shifted    = bus.mem_rdata >> {result_q[OFFW-1:0], 3'b000};
    ld_bits    = 32'd8 << ld_size_q;
    lo_mask    = '1;
    ld_sign    = 1'b0;
    ld_aligned = shifted;
    if (ld_bits < 32'(XLEN)) begin
      lo_mask    = ~({XLEN{1'b1}} << ld_bits);
      // Top bit of the truncated field: in lo_mask but not in lo_mask >> 1.
      ld_sign    = |(shifted & lo_mask & ~(lo_mask >> 1));
      ld_aligned = shifted & lo_mask;
      if (!ld_unsigned_q && ld_sign) ld_aligned = ld_aligned | ~lo_mask;
    end
  end

  // FSM, instruction capture, load-data latch and next-PC register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: every register here, datapath included, is reset so outputs never carry X.
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      snpc_q        <= '0;
      result_q      <= '0;
      rd_q          <= '0;
      wb_sel_q      <= '0;
      pc_sel_q      <= 1'b0;
      ld_size_q     <= '0;
      ld_unsigned_q <= 1'b0;
      ld_data_q     <= '0;
      dnpc_q        <= XLEN'(RESET_PC);
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      if (accept) begin
        pc_q          <= bus.in_pc;
        snpc_q        <= bus.in_snpc;
        result_q      <= bus.in_result;
        rd_q          <= bus.in_rd;
        wb_sel_q      <= bus.in_wb_sel;
        pc_sel_q      <= bus.in_pc_sel;
        ld_size_q     <= bus.in_ld_size;
        ld_unsigned_q <= bus.in_ld_unsigned;
      end
      case (state_q)
        IDLE: begin
          if (accept) state_q <= (bus.in_wb_sel == WB_MEM) ? WAIT_MEM : COMMIT;
        end
        WAIT_MEM: begin
          if (bus.mem_rvalid) begin
            ld_data_q <= ld_aligned;
            state_q   <= COMMIT;
          end
        end
        COMMIT: begin
          dnpc_q <= pc_sel_q ? result_q : snpc_q;
          if (accept) state_q <= (bus.in_wb_sel == WB_MEM) ? WAIT_MEM : COMMIT;
          else        state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Commit-side outputs; data and address follow the captured instruction.
  always_comb begin
    case (wb_sel_q)
      WB_MEM:  bus.rf_wdata = ld_data_q;
      WB_SNPC: bus.rf_wdata = snpc_q;
      default: bus.rf_wdata = result_q;
    endcase
  end

  assign bus.commit_valid = (state_q == COMMIT);
  assign bus.commit_pc    = pc_q;
  assign bus.rf_wen       = (state_q == COMMIT) && (wb_sel_q != 2'd0) && (rd_q != '0);
  assign bus.rf_waddr     = rd_q;
  assign bus.dnpc         = dnpc_q;
endmodule

// File: tb/tb_ysyx_25020047_wb_stage.sv
// Directed bench for the writeback stage: one task per scenario, inline checks.
module tb_ysyx_25020047_wb_stage;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  logic clk;
  logic rst;
  int   passed;
  int   total;

  ysyx_25020047_wb_stage_if #(.XLEN(XLEN), .REG_AW(REG_AW)) bus ();

  ysyx_25020047_wb_stage #(.XLEN(XLEN), .REG_AW(REG_AW), .RESET_PC(32'h8000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] snpc,
                       input logic [31:0] result, input logic [4:0] rd,
                       input logic [1:0] wb_sel, input logic pc_sel,
                       input logic [1:0] ld_size, input logic ld_uns);
    bus.in_valid       = 1'b1;
    bus.in_pc          = pc;
    bus.in_snpc        = snpc;
    bus.in_result      = result;
    bus.in_rd          = rd;
    bus.in_wb_sel      = wb_sel;
    bus.in_pc_sel      = pc_sel;
    bus.in_ld_size     = ld_size;
    bus.in_ld_unsigned = ld_uns;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    total++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); else passed++;
    total++; if (bus.commit_valid !== 1'b0) $display("FAIL reset_commit_valid: got %b want 0", bus.commit_valid); else passed++;
    total++; if (bus.rf_wen !== 1'b0) $display("FAIL reset_rf_wen: got %b want 0", bus.rf_wen); else passed++;
    total++; if (bus.dnpc !== 32'h8000_0000) $display("FAIL reset_dnpc: got %h want 80000000", bus.dnpc); else passed++;
    total++; if (bus.rf_waddr !== 5'd0) $display("FAIL reset_rf_waddr: got %h want 0", bus.rf_waddr); else passed++;
    total++; if (bus.rf_wdata !== 32'h0) $display("FAIL reset_rf_wdata: got %h want 0", bus.rf_wdata); else passed++;
    total++; if (bus.commit_pc !== 32'h0) $display("FAIL reset_commit_pc: got %h want 0", bus.commit_pc); else passed++;
    rst = 1'b0;
    tick();
    total++; if (bus.in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b want 1", bus.in_ready); else passed++;
  endtask

  task automatic test_addi();
    drive(32'h8000_0000, 32'h8000_0004, 32'h0000_1234, 5'd5, 2'd1, 1'b0, 2'd0, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    total++; if (bus.commit_valid !== 1'b1) $display("FAIL addi_commit_valid: got %b want 1", bus.commit_valid); else passed++;
    total++; if (bus.rf_wen !== 1'b1) $display("FAIL addi_rf_wen: got %b want 1", bus.rf_wen); else passed++;
    total++; if (bus.rf_waddr !== 5'd5) $display("FAIL addi_rf_waddr: got %0d want 5", bus.rf_waddr); else passed++;
    total++; if (bus.rf_wdata !== 32'h0000_1234) $display("FAIL addi_rf_wdata: got %h want 00001234", bus.rf_wdata); else passed++;
    total++; if (bus.commit_pc !== 32'h8000_0000) $display("FAIL addi_commit_pc: got %h want 80000000", bus.commit_pc); else passed++;
    tick();
    total++; if (bus.dnpc !== 32'h8000_0004) $display("FAIL addi_dnpc: got %h want 80000004", bus.dnpc); else passed++;
    total++; if (bus.commit_valid !== 1'b0) $display("FAIL addi_single_pulse: got %b want 0", bus.commit_valid); else passed++;
  endtask

  task automatic test_jal();
    drive(32'h8000_0004, 32'h8000_0008, 32'h8000_0100, 5'd1, 2'd3, 1'b1, 2'd0, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    total++; if (bus.rf_wen !== 1'b1) $display("FAIL jal_rf_wen: got %b want 1", bus.rf_wen); else passed++;
    total++; if (bus.rf_wdata !== 32'h8000_0008) $display("FAIL jal_rf_wdata: got %h want 80000008", bus.rf_wdata); else passed++;
    tick();
    total++; if (bus.dnpc !== 32'h8000_0100) $display("FAIL jal_dnpc: got %h want 80000100", bus.dnpc); else passed++;
  endtask

  task automatic test_load();
    // lbu, data returned the cycle after accept.
    drive(32'h8000_0100, 32'h8000_0104, 32'h8000_0003, 5'd10, 2'd2, 1'b0, 2'd0, 1'b1);
    tick();
    bus.in_valid   = 1'b0;
    bus.in_result  = 32'hDEAD_BEEF;  // upstream changes after accept must not matter
    total++; if (bus.in_ready !== 1'b0) $display("FAIL lbu_wait_in_ready: got %b want 0", bus.in_ready); else passed++;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h80FF_0000;
    tick();
    bus.mem_rvalid = 1'b0;
    total++; if (bus.commit_valid !== 1'b1) $display("FAIL lbu_commit_valid: got %b want 1", bus.commit_valid); else passed++;
    total++; if (bus.rf_wdata !== 32'h0000_0080) $display("FAIL lbu_rf_wdata: got %h want 00000080", bus.rf_wdata); else passed++;
    total++; if (bus.rf_waddr !== 5'd10) $display("FAIL lbu_rf_waddr: got %0d want 10", bus.rf_waddr); else passed++;
    tick();
    total++; if (bus.dnpc !== 32'h8000_0104) $display("FAIL lbu_dnpc: got %h want 80000104", bus.dnpc); else passed++;
    // lb, data delayed three cycles; a stray rvalid in IDLE beforehand is ignored.
    bus.mem_rvalid = 1'b1;
    tick();
    bus.mem_rvalid = 1'b0;
    total++; if (bus.commit_valid !== 1'b0) $display("FAIL idle_rvalid_ignored: got %b want 0", bus.commit_valid); else passed++;
    drive(32'h8000_0104, 32'h8000_0108, 32'h8000_0003, 5'd11, 2'd2, 1'b0, 2'd0, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.in_ready !== 1'b0 || bus.commit_valid !== 1'b0)
        $display("FAIL lb_wait%0d: in_ready=%b commit_valid=%b want 0 0", i, bus.in_ready, bus.commit_valid);
      else passed++;
      tick();
    end
    total++; if (bus.in_ready !== 1'b0) $display("FAIL lb_wait3_in_ready: got %b want 0", bus.in_ready); else passed++;
    bus.mem_rvalid = 1'b1;
    tick();
    bus.mem_rvalid = 1'b0;
    total++; if (bus.commit_valid !== 1'b1) $display("FAIL lb_commit_valid: got %b want 1", bus.commit_valid); else passed++;
    total++; if (bus.rf_wdata !== 32'hFFFF_FF80) $display("FAIL lb_rf_wdata: got %h want ffffff80", bus.rf_wdata); else passed++;
    // lhu at offset 2 of the same word: 0x80FF.
    tick();
    drive(32'h8000_0108, 32'h8000_010C, 32'h8000_0002, 5'd12, 2'd2, 1'b0, 2'd1, 1'b1);
    tick();
    bus.in_valid   = 1'b0;
    bus.mem_rvalid = 1'b1;
    tick();
    bus.mem_rvalid = 1'b0;
    total++; if (bus.rf_wdata !== 32'h0000_80FF) $display("FAIL lhu_rf_wdata: got %h want 000080ff", bus.rf_wdata); else passed++;
    tick();
  endtask

  task automatic test_no_write();
    drive(32'h8000_0200, 32'h8000_0204, 32'h8000_0300, 5'd7, 2'd0, 1'b1, 2'd0, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    total++; if (bus.rf_wen !== 1'b0) $display("FAIL beq_rf_wen: got %b want 0", bus.rf_wen); else passed++;
    total++; if (bus.commit_valid !== 1'b1) $display("FAIL beq_commit_valid: got %b want 1", bus.commit_valid); else passed++;
    tick();
    total++; if (bus.dnpc !== 32'h8000_0300) $display("FAIL beq_dnpc: got %h want 80000300", bus.dnpc); else passed++;
    drive(32'h8000_0300, 32'h8000_0304, 32'h0000_0055, 5'd0, 2'd1, 1'b0, 2'd0, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    total++; if (bus.rf_wen !== 1'b0) $display("FAIL addi_x0_rf_wen: got %b want 0", bus.rf_wen); else passed++;
    total++; if (bus.commit_valid !== 1'b1) $display("FAIL addi_x0_commit_valid: got %b want 1", bus.commit_valid); else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] pc;
    for (int i = 0; i < 4; i++) begin
      pc = 32'h8000_1000 + 32'(4 * i);
      drive(pc, pc + 32'd4, 32'(100 + i), 5'(i + 1), 2'd1, 1'b0, 2'd0, 1'b0);
      if (i > 0) begin
        total++; if (bus.in_ready !== 1'b1) $display("FAIL b2b_in_ready%0d: got %b want 1", i, bus.in_ready); else passed++;
      end
      tick();
      total++; if (bus.commit_valid !== 1'b1 || bus.commit_pc !== pc)
        $display("FAIL b2b_commit%0d: valid=%b pc=%h want 1 %h", i, bus.commit_valid, bus.commit_pc, pc);
      else passed++;
      total++; if (bus.rf_wdata !== 32'(100 + i) || bus.rf_waddr !== 5'(i + 1))
        $display("FAIL b2b_write%0d: waddr=%0d wdata=%h want %0d %h", i, bus.rf_waddr, bus.rf_wdata, i + 1, 100 + i);
      else passed++;
    end
    bus.in_valid = 1'b0;
    tick();
    total++; if (bus.commit_valid !== 1'b0) $display("FAIL b2b_end_commit_valid: got %b want 0", bus.commit_valid); else passed++;
    total++; if (bus.dnpc !== 32'h8000_1010) $display("FAIL b2b_dnpc: got %h want 80001010", bus.dnpc); else passed++;
  endtask

  task automatic test_reset_mid_wait();
    drive(32'h8000_2000, 32'h8000_2004, 32'h8000_0000, 5'd9, 2'd2, 1'b0, 2'd2, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    total++; if (bus.in_ready !== 1'b0) $display("FAIL rstwait_in_wait: got %b want 0", bus.in_ready); else passed++;
    rst = 1'b1;
    #1;
    total++; if (bus.dnpc !== 32'h8000_0000) $display("FAIL rstwait_dnpc: got %h want 80000000", bus.dnpc); else passed++;
    tick();
    rst = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1234_5678;
    tick();
    bus.mem_rvalid = 1'b0;
    total++; if (bus.commit_valid !== 1'b0) $display("FAIL rstwait_no_commit: got %b want 0", bus.commit_valid); else passed++;
    total++; if (bus.rf_wen !== 1'b0) $display("FAIL rstwait_rf_wen: got %b want 0", bus.rf_wen); else passed++;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL rstwait_in_ready: got %b want 1", bus.in_ready); else passed++;
    tick();
    total++; if (bus.commit_valid !== 1'b0 || bus.dnpc !== 32'h8000_0000)
      $display("FAIL rstwait_idle: valid=%b dnpc=%h want 0 80000000", bus.commit_valid, bus.dnpc);
    else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b1;
    bus.in_valid       = 1'b0;
    bus.in_pc          = '0;
    bus.in_snpc        = '0;
    bus.in_result      = '0;
    bus.in_rd          = '0;
    bus.in_wb_sel      = '0;
    bus.in_pc_sel      = 1'b0;
    bus.in_ld_size     = '0;
    bus.in_ld_unsigned = 1'b0;
    bus.mem_rvalid     = 1'b0;
    bus.mem_rdata      = '0;
    test_reset();
    test_addi();
    test_jal();
    test_load();
    test_no_write();
    test_back_to_back();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
